// File: rtl/pc_next_unit.sv
// rtl/pc_next_unit.sv - PC register, next-PC select and external-interrupt trap FSM.
// Define IRQ_SYNC_EN to pass IRQ through a two-flop synchronizer before the FSM.
module pc_next_unit #(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter logic [31:0] ILLOP_ADDR = 32'h8000_0004,
  parameter logic [31:0] XADR       = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  PCSrc,
  input  logic        BranchCond,
  input  logic [31:0] ConBA,
  input  logic [25:0] JT,
  input  logic [31:0] DataBusA,
  input  logic        IRQ,
  input  logic        Stall,
  output logic [31:0] PC,
  output logic [31:0] NewPC,
  output logic        IRQTaken,
  output logic        XpWr,
  output logic [31:0] XpData,
  output logic        IRQAck
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PEND = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [31:0] pc_q, pc_d;
  logic [1:0]  state_q, state_d;
  logic        irq_s;
  logic        take;

`ifdef IRQ_SYNC_EN
  logic [1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[0], IRQ};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign irq_s = sync_q[1];
`else
  assign irq_s = IRQ;
`endif

  // Increment stays within the current half so user code never walks into supervisor space.
  assign NewPC = {pc_q[31], pc_q[30:0] + 31'd4};

  assign take = (state_q == ST_PEND) && irq_s && !pc_q[31] && !Stall &&
                (PCSrc != 3'd4) && (PCSrc != 3'd5);

  always_comb begin
    pc_d = pc_q;
    if (!Stall) begin
      if (PCSrc == 3'd4) begin
        pc_d = ILLOP_ADDR;
      end else if (PCSrc == 3'd5) begin
        pc_d = XADR;
      end else if (take) begin
        pc_d = XADR;
      end else begin
        case (PCSrc)
          3'd1:    pc_d = BranchCond ? {pc_q[31], ConBA[30:0]} : NewPC;
          3'd2:    pc_d = {pc_q[31], NewPC[30:28], JT, 2'b00};
          // jr may drop the supervisor bit but can never raise it.
          3'd3:    pc_d = {pc_q[31] & DataBusA[31], DataBusA[30:0]};
          default: pc_d = NewPC;
        endcase
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (irq_s) state_d = ST_PEND;
      ST_PEND: begin
        if (take) begin
          state_d = ST_WAIT;
        end else if (!irq_s) begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: if (!irq_s) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      state_q <= ST_IDLE;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  assign PC       = pc_q;
  assign IRQTaken = take;
  assign XpWr     = take;
  assign XpData   = pc_q;
  assign IRQAck   = (state_q == ST_WAIT);

endmodule

// File: tb/tb_pc_next_unit.sv
// tb/tb_pc_next_unit.sv - self-checking bench for pc_next_unit against a behavioural PC/trap model.
module tb_pc_next_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  PCSrc;
  logic        BranchCond;
  logic [31:0] ConBA;
  logic [25:0] JT;
  logic [31:0] DataBusA;
  logic        IRQ;
  logic        Stall;
  logic [31:0] PC;
  logic [31:0] NewPC;
  logic        IRQTaken;
  logic        XpWr;
  logic [31:0] XpData;
  logic        IRQAck;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: architectural PC plus "request seen, waiting to trap" and "trap taken, waiting for drop".
  logic [31:0] m_pc;
  bit          m_pend;
  bit          m_ack;

  pc_next_unit dut (
    .clk        (clk),
    .reset      (reset),
    .PCSrc      (PCSrc),
    .BranchCond (BranchCond),
    .ConBA      (ConBA),
    .JT         (JT),
    .DataBusA   (DataBusA),
    .IRQ        (IRQ),
    .Stall      (Stall),
    .PC         (PC),
    .NewPC      (NewPC),
    .IRQTaken   (IRQTaken),
    .XpWr       (XpWr),
    .XpData     (XpData),
    .IRQAck     (IRQAck)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_newpc(input logic [31:0] pc);
    return (pc & 32'h8000_0000) | ((pc + 32'd4) & 32'h7FFF_FFFF);
  endfunction

  function automatic bit ref_take();
    return m_pend && (IRQ == 1'b1) && (m_pc < 32'h8000_0000) && (Stall == 1'b0) &&
           (PCSrc != 3'd4) && (PCSrc != 3'd5);
  endfunction

  function automatic logic [31:0] ref_next_pc();
    logic [31:0] np;
    logic [31:0] hi;
    np = ref_newpc(m_pc);
    hi = m_pc & 32'h8000_0000;
    if (Stall) return m_pc;
    if (PCSrc == 3'd4) return 32'h8000_0004;
    if (PCSrc == 3'd5) return 32'h8000_0008;
    if (ref_take()) return 32'h8000_0008;
    if (PCSrc == 3'd1) return BranchCond ? (hi | (ConBA & 32'h7FFF_FFFF)) : np;
    if (PCSrc == 3'd2) return hi | (np & 32'h7000_0000) | ({6'd0, JT} * 32'd4);
    if (PCSrc == 3'd3) return (hi & DataBusA & 32'h8000_0000) | (DataBusA & 32'h7FFF_FFFF);
    return np;
  endfunction

  task automatic set_in(input logic [2:0] src, input logic bc, input logic [31:0] cba,
                        input logic [25:0] jt, input logic [31:0] dba, input logic irq,
                        input logic stall);
    PCSrc      = src;
    BranchCond = bc;
    ConBA      = cba;
    JT         = jt;
    DataBusA   = dba;
    IRQ        = irq;
    Stall      = stall;
    #1;
  endtask

  task automatic tick();
    logic [31:0] npc;
    bit          take, np, na;
    take = ref_take();
    npc  = ref_next_pc();
    if (m_ack) begin
      np = 1'b0;
      na = IRQ;
    end else if (m_pend) begin
      np = take ? 1'b0 : IRQ;
      na = take;
    end else begin
      np = IRQ;
      na = 1'b0;
    end
    @(posedge clk);
    #1;
    if (reset) begin
      m_pc   = 32'h8000_0000;
      m_pend = 1'b0;
      m_ack  = 1'b0;
    end else begin
      m_pc   = npc;
      m_pend = np;
      m_ack  = na;
    end
  endtask

  task automatic hw_reset();
    reset = 1'b1;
    set_in(3'd0, 1'b0, 32'd0, 26'd0, 32'd0, 1'b0, 1'b0);
    m_pc   = 32'h8000_0000;
    m_pend = 1'b0;
    m_ack  = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_in(3'd0, 1'b0, 32'd0, 26'd0, 32'd0, 1'b1, 1'b0);
    n_checks += 5;
    if (PC !== 32'h8000_0000) begin n_fail++; $display("FAIL reset_pc got %h want 80000000", PC); end
    if (NewPC !== 32'h8000_0004) begin n_fail++; $display("FAIL reset_newpc got %h want 80000004", NewPC); end
    if (XpData !== 32'h8000_0000) begin n_fail++; $display("FAIL reset_xpdata got %h want 80000000", XpData); end
    if (IRQTaken !== 1'b0 || XpWr !== 1'b0) begin n_fail++; $display("FAIL reset_taken got %b/%b want 0/0", IRQTaken, XpWr); end
    if (IRQAck !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b want 0", IRQAck); end
    hw_reset();
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    hw_reset();
    exp_pc = 32'h8000_0000;
    for (int i = 0; i < 4; i++) begin
      set_in(3'd0, 1'b0, 32'd0, 26'd0, 32'd0, 1'b0, 1'b0);
      n_checks++;
      if (PC !== exp_pc) begin n_fail++; $display("FAIL seq_pc step %0d got %h want %h", i, PC, exp_pc); end
      tick();
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_branch();
    hw_reset();
    set_in(3'd3, 1'b0, 32'd0, 26'd0, 32'h0040_0010, 1'b0, 1'b0);
    tick();
    set_in(3'd1, 1'b1, 32'h0040_0100, 26'd0, 32'd0, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (PC !== 32'h0040_0100) begin n_fail++; $display("FAIL branch_taken got %h want 00400100", PC); end
    set_in(3'd3, 1'b0, 32'd0, 26'd0, 32'h0040_0010, 1'b0, 1'b0);
    tick();
    set_in(3'd1, 1'b0, 32'h0040_0100, 26'd0, 32'd0, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (PC !== 32'h0040_0014) begin n_fail++; $display("FAIL branch_not_taken got %h want 00400014", PC); end
  endtask

  task automatic test_jr_jump();
    hw_reset();
    set_in(3'd3, 1'b0, 32'd0, 26'd0, 32'h8000_0020, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (PC !== 32'h8000_0020) begin n_fail++; $display("FAIL jr_super got %h want 80000020", PC); end
    set_in(3'd3, 1'b0, 32'd0, 26'd0, 32'h0040_0000, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (PC !== 32'h0040_0000) begin n_fail++; $display("FAIL jr_to_user got %h want 00400000", PC); end
    set_in(3'd3, 1'b0, 32'd0, 26'd0, 32'h8000_1000, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (PC !== 32'h0000_1000) begin n_fail++; $display("FAIL jr_no_escalate got %h want 00001000", PC); end
    set_in(3'd2, 1'b0, 32'd0, 26'h012_3456, 32'd0, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (PC !== 32'h0048_D158) begin n_fail++; $display("FAIL jump got %h want 0048d158", PC); end
    set_in(3'd3, 1'b0, 32'd0, 26'd0, 32'h7FFF_FFFC, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (NewPC !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_user got %h want 00000000", NewPC); end
    hw_reset();
    set_in(3'd3, 1'b0, 32'd0, 26'd0, 32'hFFFF_FFFC, 1'b0, 1'b0);
    tick();
    set_in(3'd0, 1'b0, 32'd0, 26'd0, 32'd0, 1'b0, 1'b0);
    n_checks++;
    if (NewPC !== 32'h8000_0000) begin n_fail++; $display("FAIL wrap_super got %h want 80000000", NewPC); end
    tick();
    n_checks++;
    if (PC !== 32'h8000_0000) begin n_fail++; $display("FAIL wrap_super_pc got %h want 80000000", PC); end
  endtask

  task automatic test_irq();
    hw_reset();
    set_in(3'd3, 1'b0, 32'd0, 26'd0, 32'h0040_0020, 1'b1, 1'b0);
    n_checks++;
    if (IRQTaken !== 1'b0) begin n_fail++; $display("FAIL irq_idle_taken got %b want 0", IRQTaken); end
    tick();
    set_in(3'd0, 1'b0, 32'd0, 26'd0, 32'd0, 1'b1, 1'b0);
    n_checks += 3;
    if (IRQTaken !== 1'b1 || XpWr !== 1'b1) begin n_fail++; $display("FAIL irq_take got %b/%b want 1/1", IRQTaken, XpWr); end
    if (XpData !== 32'h0040_0020) begin n_fail++; $display("FAIL irq_xpdata got %h want 00400020", XpData); end
    if (IRQAck !== 1'b0) begin n_fail++; $display("FAIL irq_ack_early got %b want 0", IRQAck); end
    tick();
    n_checks += 3;
    if (PC !== 32'h8000_0008) begin n_fail++; $display("FAIL irq_vector got %h want 80000008", PC); end
    if (IRQAck !== 1'b1) begin n_fail++; $display("FAIL irq_ack got %b want 1", IRQAck); end
    if (IRQTaken !== 1'b0) begin n_fail++; $display("FAIL irq_no_retrigger got %b want 0", IRQTaken); end
    set_in(3'd3, 1'b0, 32'd0, 26'd0, 32'h0040_0020, 1'b1, 1'b0);
    tick();
    n_checks += 2;
    if (IRQTaken !== 1'b0) begin n_fail++; $display("FAIL irq_wait_hold got %b want 0", IRQTaken); end
    if (IRQAck !== 1'b1) begin n_fail++; $display("FAIL irq_wait_ack got %b want 1", IRQAck); end
    set_in(3'd0, 1'b0, 32'd0, 26'd0, 32'd0, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (IRQAck !== 1'b0) begin n_fail++; $display("FAIL irq_release got %b want 0", IRQAck); end
  endtask

  task automatic test_masked();
    hw_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(3'd0, 1'b0, 32'd0, 26'd0, 32'd0, 1'b1, 1'b0);
      n_checks++;
      if (IRQTaken !== 1'b0) begin n_fail++; $display("FAIL masked_taken step %0d got %b want 0", i, IRQTaken); end
      tick();
    end
    set_in(3'd3, 1'b0, 32'd0, 26'd0, 32'h0040_0000, 1'b1, 1'b0);
    tick();
    set_in(3'd0, 1'b0, 32'd0, 26'd0, 32'd0, 1'b1, 1'b0);
    n_checks++;
    if (IRQTaken !== 1'b1) begin n_fail++; $display("FAIL masked_then_take got %b want 1", IRQTaken); end
    tick();
    n_checks++;
    if (PC !== 32'h8000_0008) begin n_fail++; $display("FAIL masked_vector got %h want 80000008", PC); end
    set_in(3'd0, 1'b0, 32'd0, 26'd0, 32'd0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_stall();
    hw_reset();
    set_in(3'd3, 1'b0, 32'd0, 26'd0, 32'h0040_0000, 1'b0, 1'b0);
    tick();
    set_in(3'd4, 1'b0, 32'd0, 26'd0, 32'd0, 1'b1, 1'b1);
    tick();
    set_in(3'd4, 1'b0, 32'd0, 26'd0, 32'd0, 1'b1, 1'b1);
    n_checks += 2;
    if (IRQTaken !== 1'b0) begin n_fail++; $display("FAIL stall_taken got %b want 0", IRQTaken); end
    if (NewPC !== 32'h0040_0004) begin n_fail++; $display("FAIL stall_newpc got %h want 00400004", NewPC); end
    tick();
    set_in(3'd5, 1'b0, 32'd0, 26'd0, 32'd0, 1'b1, 1'b1);
    tick();
    n_checks++;
    if (PC !== 32'h0040_0000) begin n_fail++; $display("FAIL stall_hold got %h want 00400000", PC); end
    set_in(3'd4, 1'b0, 32'd0, 26'd0, 32'd0, 1'b1, 1'b0);
    n_checks++;
    if (IRQTaken !== 1'b0) begin n_fail++; $display("FAIL illop_over_irq got %b want 0", IRQTaken); end
    tick();
    n_checks++;
    if (PC !== 32'h8000_0004) begin n_fail++; $display("FAIL stall_release got %h want 80000004", PC); end
    set_in(3'd0, 1'b0, 32'd0, 26'd0, 32'd0, 1'b1, 1'b0);
    n_checks++;
    if (IRQTaken !== 1'b0) begin n_fail++; $display("FAIL illop_masked got %b want 0", IRQTaken); end
    tick();
    set_in(3'd0, 1'b0, 32'd0, 26'd0, 32'd0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_reset_mid_trap();
    hw_reset();
    set_in(3'd3, 1'b0, 32'd0, 26'd0, 32'h0040_0100, 1'b1, 1'b0);
    tick();
    set_in(3'd0, 1'b0, 32'd0, 26'd0, 32'd0, 1'b1, 1'b0);
    reset = 1'b1;
    #1;
    n_checks += 3;
    if (PC !== 32'h8000_0000) begin n_fail++; $display("FAIL midtrap_pc got %h want 80000000", PC); end
    if (IRQTaken !== 1'b0) begin n_fail++; $display("FAIL midtrap_taken got %b want 0", IRQTaken); end
    if (IRQAck !== 1'b0) begin n_fail++; $display("FAIL midtrap_ack got %b want 0", IRQAck); end
    m_pc   = 32'h8000_0000;
    m_pend = 1'b0;
    m_ack  = 1'b0;
    tick();
    reset = 1'b0;
    set_in(3'd3, 1'b0, 32'd0, 26'd0, 32'h0040_0200, 1'b1, 1'b0);
    tick();
    n_checks++;
    if (IRQTaken !== 1'b1) begin n_fail++; $display("FAIL midtrap_reenter got %b want 1", IRQTaken); end
    set_in(3'd0, 1'b0, 32'd0, 26'd0, 32'd0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_random();
    int unsigned r;
    logic [2:0]  src;
    logic        irq;
    hw_reset();
    irq = 1'b0;
    for (int i = 0; i < 600; i++) begin
      r   = $urandom_range(0, 11);
      src = (r > 7) ? 3'd3 : 3'(r);
      if ($urandom_range(0, 3) == 0) irq = ~irq;
      set_in(src, 1'($urandom_range(0, 1)), $urandom, 26'($urandom), $urandom, irq,
             $urandom_range(0, 5) == 0);
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b1;
        #1;
        m_pc   = 32'h8000_0000;
        m_pend = 1'b0;
        m_ack  = 1'b0;
      end
      n_checks += 5;
      if (PC !== m_pc) begin n_fail++; $display("FAIL rand_pc cyc %0d got %h want %h", i, PC, m_pc); end
      if (NewPC !== ref_newpc(m_pc)) begin n_fail++; $display("FAIL rand_newpc cyc %0d got %h want %h", i, NewPC, ref_newpc(m_pc)); end
      if (XpData !== m_pc) begin n_fail++; $display("FAIL rand_xpdata cyc %0d got %h want %h", i, XpData, m_pc); end
      if (IRQTaken !== ref_take() || XpWr !== ref_take()) begin
        n_fail++; $display("FAIL rand_taken cyc %0d got %b/%b want %b", i, IRQTaken, XpWr, ref_take());
      end
      if (IRQAck !== m_ack) begin n_fail++; $display("FAIL rand_ack cyc %0d got %b want %b", i, IRQAck, m_ack); end
      tick();
      reset = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jr_jump();
    test_irq();
    test_masked();
    test_stall();
    test_reset_mid_trap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
